multi_band_scale: RTL and testbench

MULTI_BAND_SCALE -- requirements
Module: multi_band_scale

---
 rtl/band_scale_pkg.sv | 24 ++
 rtl/gain_ramp.sv | 45 ++++
 rtl/multi_band_scale.sv | 154 +++++++++++++++
 tb/tb_multi_band_scale.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/band_scale_pkg.sv
// rtl/band_scale_pkg.sv - shared widths, channel-index width and saturation limits
package band_scale_pkg;

    localparam int DEF_NCH        = 4;
    localparam int DEF_AUD_W      = 16;
    localparam int DEF_POT_W      = 12;
    localparam int DEF_RAMP_SHIFT = 4;

    // Channel index width; a single channel still gets one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest positive value of a w-bit two's complement sample
    function automatic longint sat_pos(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Most negative value of a w-bit two's complement sample
    function automatic longint sat_neg(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// rtl/gain_ramp.sv - one channel: squared-pot target and smoothed current gain
module gain_ramp #(
    parameter int POT_W      = 12,
    parameter int RAMP_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POT_W-1:0] i_pot,
    input  logic             i_mute,
    input  logic             i_upd,
    output logic [POT_W-1:0] o_gain
);

    logic [2*POT_W-1:0] w_pot_ext;
    logic [POT_W-1:0]   w_target;
    logic [POT_W-1:0]   w_diff;
    logic [POT_W-1:0]   w_step;
    logic               w_up;
    logic [POT_W-1:0]   r_gain;

    // Target is pot squared (audio taper) scaled back to POT_W, forced to zero on mute;
    // step is a fraction of the distance, never zero while distance remains, never past target
    always_comb begin
        w_pot_ext = {{POT_W{1'b0}}, i_pot};
        w_target  = i_mute ? '0 : POT_W'((w_pot_ext * w_pot_ext) >> POT_W);
        w_up      = (w_target >= r_gain);
        w_diff    = w_up ? (w_target - r_gain) : (r_gain - w_target);
        w_step    = w_diff >> RAMP_SHIFT;
        if ((w_step == '0) && (w_diff != '0)) begin
            w_step = POT_W'(1);
        end
    end

    // Gain moves only when a sample of this channel is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain <= '0;
        end else if (i_upd) begin
            r_gain <= w_up ? (r_gain + w_step) : (r_gain - w_step);
        end
    end

    assign o_gain = r_gain;

endmodule

// File: rtl/multi_band_scale.sv
// rtl/multi_band_scale.sv - per-channel smoothed gain scaling with saturation, 3-stage pipeline
module multi_band_scale
    import band_scale_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int AUD_W      = DEF_AUD_W,
    parameter int POT_W      = DEF_POT_W,
    parameter int GAIN_SHIFT = POT_W - 2,
    parameter int RAMP_SHIFT = DEF_RAMP_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*POT_W-1:0]     pot,
    input  logic [NCH-1:0]           mute,
    input  logic                     in_valid,
    input  logic [ch_width(NCH)-1:0] in_ch,
    input  logic signed [AUD_W-1:0]  in_audio,
    output logic                     out_valid,
    output logic [ch_width(NCH)-1:0] out_ch,
    output logic signed [AUD_W-1:0]  out_audio,
    output logic [NCH-1:0]           sat_flag,
    input  logic [NCH-1:0]           sat_clr
);

    localparam int CH_W = ch_width(NCH);
    localparam int P_W  = AUD_W + POT_W + 1;
    localparam logic [AUD_W-1:0] SAT_POS = AUD_W'(sat_pos(AUD_W));
    localparam logic [AUD_W-1:0] SAT_NEG = AUD_W'(sat_neg(AUD_W));

    logic [POT_W-1:0]        w_gain [NCH];
    logic [POT_W-1:0]        w_sel_gain;
    logic                    w_accept;
    logic signed [P_W-1:0]   w_gain_ext;
    logic signed [P_W-1:0]   w_audio_ext;
    logic signed [P_W-1:0]   w_prod;
    logic signed [P_W-1:0]   w_shift;
    logic [P_W-AUD_W:0]      w_hi;
    logic                    w_ovf;
    logic [AUD_W-1:0]        w_res;
    logic [NCH-1:0]          w_sat_set;

    logic                    r1_valid;
    logic [CH_W-1:0]         r1_ch;
    logic signed [AUD_W-1:0] r1_audio;
    logic [POT_W-1:0]        r1_gain;
    logic                    r2_valid;
    logic [CH_W-1:0]         r2_ch;
    logic signed [P_W-1:0]   r2_prod;
    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic signed [AUD_W-1:0] r_out_audio;
    logic [NCH-1:0]          r_sat_flag;

    assign w_accept = in_valid && (int'(in_ch) < NCH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gain_ramp #(
            .POT_W      (POT_W),
            .RAMP_SHIFT (RAMP_SHIFT)
        ) u_ramp (
            .clk    (clk),
            .rst    (rst),
            .i_pot  (pot[c*POT_W +: POT_W]),
            .i_mute (mute[c]),
            .i_upd  (w_accept && (int'(in_ch) == c)),
            .o_gain (w_gain[c])
        );
    end

    // Pick the addressed channel's gain as it stands before this sample updates it
    always_comb begin
        w_sel_gain = '0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(in_ch) == c) begin
                w_sel_gain = w_gain[c];
            end
        end
    end

    // Stage 1: capture sample, channel and pre-update gain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_ch    <= '0;
            r1_audio <= '0;
            r1_gain  <= '0;
        end else begin
            r1_valid <= w_accept;
            if (w_accept) begin
                r1_ch    <= in_ch;
                r1_audio <= in_audio;
                r1_gain  <= w_sel_gain;
            end
        end
    end

    // Gain is treated as non-negative by prefixing a zero sign bit
    assign w_gain_ext  = P_W'($signed({1'b0, r1_gain}));
    assign w_audio_ext = P_W'(r1_audio);
    assign w_prod      = w_gain_ext * w_audio_ext;

    // Stage 2: full-width signed product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_ch    <= '0;
            r2_prod  <= '0;
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_ch   <= r1_ch;
                r2_prod <= w_prod;
            end
        end
    end

    assign w_shift = r2_prod >>> GAIN_SHIFT;
    assign w_hi    = w_shift[P_W-1:AUD_W-1];

    // Overflow when the bits above the output sign are not a pure sign extension
    always_comb begin
        w_ovf     = !((&w_hi) || (~|w_hi));
        w_res     = w_ovf ? (w_shift[P_W-1] ? SAT_NEG : SAT_POS) : w_shift[AUD_W-1:0];
        w_sat_set = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r2_valid && w_ovf && (int'(r2_ch) == c)) begin
                w_sat_set[c] = 1'b1;
            end
        end
    end

    // Stage 3: register result; sticky flags where a clear beats a same-cycle set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_audio <= '0;
            r_sat_flag  <= '0;
        end else begin
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_ch    <= r2_ch;
                r_out_audio <= w_res;
            end
            r_sat_flag <= (r_sat_flag | w_sat_set) & ~sat_clr;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_audio = r_out_audio;
    assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_multi_band_scale.sv
// tb/tb_multi_band_scale.sv - randomized model-checked bench, instant-jump and smoothed instances
module tb_multi_band_scale;

    typedef struct { int cyc; int ch; int audio; } rec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [59:0]        pot_r = '0;
    logic [4:0]         mute_r = '0;
    logic [4:0]         clr_r = '0;
    logic               vld_a = 1'b0;
    logic               vld_b = 1'b0;
    logic [2:0]         ch_r = '0;
    logic signed [15:0] aud_r = '0;

    logic               ov_a, ov_b;
    logic [1:0]         oc_a;
    logic [2:0]         oc_b;
    logic signed [15:0] oa_a, oa_b;
    logic [3:0]         sf_a;
    logic [4:0]         sf_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rec_t exp0[$], exp1[$], obs0[$], obs1[$];
    int   g_m [2][5];
    int   f_m [2][5];

    multi_band_scale #(.NCH(4), .RAMP_SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .pot(pot_r[47:0]), .mute(mute_r[3:0]),
        .in_valid(vld_a), .in_ch(ch_r[1:0]), .in_audio(aud_r),
        .out_valid(ov_a), .out_ch(oc_a), .out_audio(oa_a),
        .sat_flag(sf_a), .sat_clr(clr_r[3:0])
    );

    multi_band_scale #(.NCH(5), .RAMP_SHIFT(4)) u_b (
        .clk(clk), .rst(rst), .pot(pot_r), .mute(mute_r),
        .in_valid(vld_b), .in_ch(ch_r), .in_audio(aud_r),
        .out_valid(ov_b), .out_ch(oc_b), .out_audio(oa_b),
        .sat_flag(sf_b), .sat_clr(clr_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ov_a) obs0.push_back('{cyc, int'(oc_a), int'(oa_a)});
            if (ov_b) obs1.push_back('{cyc, int'(oc_b), int'(oa_b)});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 5; c++) begin
                g_m[k][c] = 0;
                f_m[k][c] = 0;
            end
    endtask

    // Behavioural view: output = floor(audio * gain / 1024) clipped to 16 bits; gain then
    // steps toward pot^2/4096 (0 if muted) by distance/2^shift, at least 1, never past it
    task automatic model_push(input int k, input int ch, input int audio);
        int     g, t, p, d, st, rs;
        longint r;
        rec_t   e;
        rs = (k == 0) ? 0 : 4;
        g  = g_m[k][ch];
        r  = (longint'(audio) * g) >>> 10;
        if (r > 32767) begin
            r = 32767;
            f_m[k][ch] = 1;
        end else if (r < -32768) begin
            r = -32768;
            f_m[k][ch] = 1;
        end
        e = '{cyc + 3, ch, int'(r)};
        if (k == 0) exp0.push_back(e);
        else        exp1.push_back(e);
        p  = int'(pot_r[ch*12 +: 12]);
        t  = mute_r[ch] ? 0 : (p * p) / 4096;
        d  = (t > g) ? (t - g) : (g - t);
        st = d / (1 << rs);
        if (st == 0 && d != 0) st = 1;
        g_m[k][ch] = (t > g) ? (g + st) : (g - st);
    endtask

    task automatic send(input int ch, input int audio);
        ch_r  = 3'(ch);
        aud_r = 16'(audio);
        vld_a = (ch < 4);
        vld_b = (ch < 5);
        if (ch < 4) model_push(0, ch, audio);
        if (ch < 5) model_push(1, ch, audio);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        vld_a = 1'b0;
        vld_b = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        vld_a = 1'b1;
        vld_b = 1'b1;
        aud_r = 16'sd1234;
        model_clear();
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ov_a: got %b expected 0", ov_a); end
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_ov_b: got %b expected 0", ov_b); end
        checks++; if (oc_b !== 3'd0) begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", oc_b); end
        checks++; if (oa_a !== 16'sd0) begin errors++; $display("FAIL reset_out_audio: got %0d expected 0", oa_a); end
        checks++; if (sf_b !== 5'd0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sf_b); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_gain_jump();
        int base, t1;
        pot_r        = 60'({$urandom(), $urandom()});
        pot_r[11:0]  = 12'd4095;
        mute_r       = '0;
        base = obs0.size();
        send(0, 500);
        t1 = cyc;
        send(0, 1000);
        idle(5);
        checks++;
        if (obs0.size() !== base + 2) begin
            errors++; $display("FAIL jump_count: got %0d outputs expected %0d", obs0.size() - base, 2);
        end else begin
            checks++; if (obs0[base].audio !== 0) begin errors++; $display("FAIL jump_prime: got %0d expected 0", obs0[base].audio); end
            checks++; if (obs0[base+1].audio !== 3998) begin errors++; $display("FAIL jump_value: got %0d expected 3998", obs0[base+1].audio); end
            checks++; if (obs0[base+1].cyc !== t1 + 3) begin errors++; $display("FAIL jump_latency: got cycle %0d expected %0d", obs0[base+1].cyc, t1 + 3); end
        end
    endtask

    task automatic test_saturation();
        send(0, 16000); idle(5);
        checks++; if (oa_a !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", oa_a); end
        checks++; if (sf_a[0] !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sf_a[0]); end
        send(0, -16000); idle(5);
        checks++; if (oa_a !== 16'sh8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", oa_a); end
        clr_r = 5'b00001;
        f_m[0][0] = 0; f_m[1][0] = 0;
        @(posedge clk); #1;
        clr_r = '0;
        checks++; if (sf_a[0] !== 1'b0) begin errors++; $display("FAIL sat_clr: got %b expected 0", sf_a[0]); end
        // clear arrives on the same edge that would set the flag
        send(0, 16000);
        idle(1);
        clr_r = 5'b00001;
        idle(1);
        clr_r = '0;
        f_m[0][0] = 0; f_m[1][0] = 0;
        idle(3);
        checks++; if (sf_a[0] !== 1'b0) begin errors++; $display("FAIL sat_clr_priority: got %b expected 0", sf_a[0]); end
        checks++; if (oa_a !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos_again: got %h expected 7fff", oa_a); end
    endtask

    task automatic test_ramp();
        int base, bad;
        rst = 1'b1; idle(2); rst = 1'b0;
        model_clear();
        pot_r[23:12] = 12'd4095;
        base = obs1.size();
        for (int i = 0; i < 120; i++) send(1, 1024);
        idle(6);
        checks++;
        if (obs1.size() !== base + 120) begin
            errors++; $display("FAIL ramp_count: got %0d expected 120", obs1.size() - base);
        end else begin
            checks++; if (obs1[base].audio !== 0) begin errors++; $display("FAIL ramp_g0: got %0d expected 0", obs1[base].audio); end
            checks++; if (obs1[base+1].audio !== 255) begin errors++; $display("FAIL ramp_g1: got %0d expected 255", obs1[base+1].audio); end
            checks++; if (obs1[base+2].audio !== 494) begin errors++; $display("FAIL ramp_g2: got %0d expected 494", obs1[base+2].audio); end
            bad = 0;
            for (int i = base + 1; i < base + 120; i++)
                if (obs1[i].audio < obs1[i-1].audio || obs1[i].audio > 4094) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL ramp_monotonic: got %0d violations expected 0", bad); end
            checks++; if (obs1[base+119].audio !== 4094) begin errors++; $display("FAIL ramp_settle: got %0d expected 4094", obs1[base+119].audio); end
        end
    endtask

    task automatic test_mute();
        int p, tgt, base, first, last, bad, prev;
        p = 2048 + int'($urandom_range(2047));
        pot_r[35:24] = 12'(p);
        tgt = (p * p) / 4096;
        for (int i = 0; i < 120; i++) send(2, 1024);
        idle(6);
        mute_r[2] = 1'b1;
        base = obs1.size();
        for (int i = 0; i < 120; i++) begin
            send(2, 1024);
            send(3, int'($urandom_range(65535)) - 32768);
        end
        idle(6);
        first = -1; last = -1; bad = 0; prev = 1 << 20;
        for (int i = base; i < obs1.size(); i++)
            if (obs1[i].ch == 2) begin
                if (first < 0) first = obs1[i].audio;
                if (obs1[i].audio > prev) bad++;
                prev = obs1[i].audio;
                last = obs1[i].audio;
            end
        checks++; if (first !== tgt) begin errors++; $display("FAIL mute_settled: got %0d expected %0d", first, tgt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mute_monotonic: got %0d violations expected 0", bad); end
        checks++; if (last !== 0) begin errors++; $display("FAIL mute_zero: got %0d expected 0", last); end
        send(1, 1024); idle(5);
        checks++; if (oa_b !== 16'sd4094) begin errors++; $display("FAIL mute_other_ch: got %0d expected 4094", oa_b); end
        mute_r[2] = 1'b0;
    endtask

    task automatic test_interleave();
        int b0, b1, n_a, n_b, ch, c, n5;
        b0 = obs0.size(); b1 = obs1.size();
        n_a = 0; n_b = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(19) == 0) begin
                c = int'($urandom_range(4));
                pot_r[c*12 +: 12] = 12'($urandom_range(4095));
            end
            if ($urandom_range(39) == 0) begin
                c = int'($urandom_range(4));
                mute_r[c] = ~mute_r[c];
            end
            ch = int'($urandom_range(4));
            if (ch == 4) ch = 5;
            if (ch < 4) n_a++;
            if (ch < 5) n_b++;
            send(ch, int'($urandom_range(65535)) - 32768);
        end
        idle(6);
        n5 = 0;
        for (int i = b1; i < obs1.size(); i++) if (obs1[i].ch >= 5) n5++;
        checks++; if (obs0.size() - b0 !== n_a) begin errors++; $display("FAIL inter_count_a: got %0d expected %0d", obs0.size() - b0, n_a); end
        checks++; if (obs1.size() - b1 !== n_b) begin errors++; $display("FAIL inter_count_b: got %0d expected %0d", obs1.size() - b1, n_b); end
        checks++; if (n5 !== 0) begin errors++; $display("FAIL inter_drop: got %0d out-of-range results expected 0", n5); end
    endtask

    task automatic test_reset_midstream();
        int b0, b1, nz;
        mute_r = '0;
        b0 = obs0.size(); b1 = obs1.size();
        send(0, 1000);
        send(1, 1000);
        ch_r = 3'd2; aud_r = 16'sd1000; vld_a = 1'b1; vld_b = 1'b1;
        rst = 1'b1;
        void'(exp0.pop_back()); void'(exp0.pop_back());
        void'(exp1.pop_back()); void'(exp1.pop_back());
        model_clear();
        idle(2);
        rst = 1'b0;
        idle(6);
        checks++; if (obs0.size() !== b0) begin errors++; $display("FAIL rst_flight_a: got %0d outputs expected 0", obs0.size() - b0); end
        checks++; if (obs1.size() !== b1) begin errors++; $display("FAIL rst_flight_b: got %0d outputs expected 0", obs1.size() - b1); end
        pot_r = {60{1'b1}};
        for (int c = 0; c < 5; c++) send(c, 1024);
        idle(6);
        nz = 0;
        for (int i = b0; i < obs0.size(); i++) if (obs0[i].audio != 0) nz++;
        for (int i = b1; i < obs1.size(); i++) if (obs1[i].audio != 0) nz++;
        checks++; if (obs1.size() - b1 !== 5) begin errors++; $display("FAIL rst_post_count: got %0d expected 5", obs1.size() - b1); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL rst_gain_zero: got %0d nonzero outputs expected 0", nz); end
    endtask

    task automatic test_scoreboard();
        int n;
        checks++; if (obs0.size() !== exp0.size()) begin errors++; $display("FAIL sb_size_a: got %0d expected %0d", obs0.size(), exp0.size()); end
        checks++; if (obs1.size() !== exp1.size()) begin errors++; $display("FAIL sb_size_b: got %0d expected %0d", obs1.size(), exp1.size()); end
        n = (obs0.size() < exp0.size()) ? obs0.size() : exp0.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs0[i].cyc != exp0[i].cyc || obs0[i].ch != exp0[i].ch || obs0[i].audio != exp0[i].audio) begin
                errors++;
                $display("FAIL sb_a[%0d]: got cyc %0d ch %0d audio %0d expected cyc %0d ch %0d audio %0d",
                         i, obs0[i].cyc, obs0[i].ch, obs0[i].audio, exp0[i].cyc, exp0[i].ch, exp0[i].audio);
            end
        end
        n = (obs1.size() < exp1.size()) ? obs1.size() : exp1.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs1[i].cyc != exp1[i].cyc || obs1[i].ch != exp1[i].ch || obs1[i].audio != exp1[i].audio) begin
                errors++;
                $display("FAIL sb_b[%0d]: got cyc %0d ch %0d audio %0d expected cyc %0d ch %0d audio %0d",
                         i, obs1[i].cyc, obs1[i].ch, obs1[i].audio, exp1[i].cyc, exp1[i].ch, exp1[i].audio);
            end
        end
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                checks++;
                if (int'(sf_a[c]) != f_m[0][c]) begin errors++; $display("FAIL sb_flag_a[%0d]: got %b expected %0d", c, sf_a[c], f_m[0][c]); end
            end
            checks++;
            if (int'(sf_b[c]) != f_m[1][c]) begin errors++; $display("FAIL sb_flag_b[%0d]: got %b expected %0d", c, sf_b[c], f_m[1][c]); end
        end
    endtask

    initial begin
        test_reset();
        test_gain_jump();
        test_saturation();
        test_ramp();
        test_mute();
        test_interleave();
        test_reset_midstream();
        test_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
